nfca_tx_arbiter: RTL and testbench
==================================

Name: nfca_tx_arbiter

Overview:
- Frame-level arbiter and scheduler placed in front of the NFC-A TX framer's byte-stream sink.
- Shares the framer between two requesters:
  - s0: host/user command stream.
  - s1: internal protocol engine (REQA/WUPA/anticollision poller).
- Locks a grant for a whole frame, tlast inclusive.
- Tracks the framer's tx_en to know when the frame has left the antenna, then enforces a minimum PCD frame-delay gap before the next grant.

Parameters:
- GAP_CYCLES, 7032: minimum idle clk cycles after tx_en falls before the next grant (1172/fc at 81.36 MHz).
- START_TIMEOUT, 4096: max clk cycles to wait for tx_en to rise after tlast is accepted; beyond this the frame is treated as dropped.
- CNT_W, 13: width of the shared gap/timeout counter; must hold max(GAP_CYCLES, START_TIMEOUT).

Ports:
- rstn  input  1  asynchronous active-low reset (0: reset, 1: work)
- clk  input  1  system clock, 81.36 MHz
- s0_tvalid  input  1  requester 0 byte valid
- s0_tready  output  1  requester 0 byte accepted
- s0_tdata  input  8  requester 0 byte
- s0_tdatab  input  4  requester 0 valid bits in last byte, range 1..8
- s0_tlast  input  1  requester 0 end of frame
- s1_tvalid, s1_tready, s1_tdata, s1_tdatab, s1_tlast: same as s0, for requester 1
- m_tvalid  output  1  to framer tx_tvalid
- m_tready  input  1  from framer tx_tready
- m_tdata  output  8  to framer tx_tdata
- m_tdatab  output  4  to framer tx_tdatab
- m_tlast  output  1  to framer tx_tlast
- tx_en  input  1  framer modulator-enable output, monitored only
- grant  output  2  one-hot current owner; 00 when none
- busy  output  1  1 whenever state != IDLE
- drop_err  output  1  one-cycle pulse on START_TIMEOUT expiry

Behaviour:
- Reset: grant=00, busy=0, drop_err=0, last_owner=1 (so s0 wins the first tie), counter=0, state=IDLE.
  - Reset is asynchronous and may be asserted mid-frame.
  - All m_* and s*_tready must be 0 while rstn=0.
- Datapath is combinational mux with zero latency, selected by grant:
  - m_tvalid = OR over i of (grant[i] & si_tvalid).
  - si_tready = grant[i] & m_tready.
  - m_tdata, m_tdatab and m_tlast come from the granted requester; they are 0 when grant=00.
- State machine:
  - IDLE:
    - If only one requester has tvalid=1, grant that one.
    - If both do, grant the one != last_owner.
    - Register grant, then go to SEND. The grant is visible the cycle after the request is sampled.
  - SEND:
    - Pass bytes through.
    - On the handshake (m_tvalid & m_tready & m_tlast): set last_owner=owner, clear counter, go to WAIT_START.
    - Grant stays held until this transition, then drops to 00 in the same cycle the state leaves SEND.
  - WAIT_START:
    - If tx_en=1, go to WAIT_END.
    - Otherwise, when counter reaches START_TIMEOUT-1, pulse drop_err and go to GAP. This covers a framer overflow that discards the frame.
  - WAIT_END: when tx_en=0, clear counter and go to GAP.
  - GAP: count up; at GAP_CYCLES-1 go to IDLE.
- No requester is granted outside IDLE. Requester tvalid arriving during WAIT_START, WAIT_END or GAP is held off because tready=0.
- A requester may drop tvalid mid-frame in SEND. The grant is still held; no timeout applies in SEND.
- Counter saturates and never wraps; it is cleared on every state entry.

Decomposition:
- Shared package nfca_pkg holds:
  - state encoding (IDLE, SEND, WAIT_START, WAIT_END, GAP);
  - the FDT constant 1172 and the clk-per-fc ratio 6, from which GAP_CYCLES is derived.
- No sub-module is needed. The counter and mux stay inline in the single module.

Test Plan:
- Single frame: s0 sends 3 bytes {93,20,xx} with tlast on byte 3; framer asserts tx_en for 3000 cycles -> grant=01 for exactly 3 handshakes, then 00; busy stays 1 until 7032 cycles after tx_en falls.
- Contention: s0 and s1 both valid in the same IDLE cycle after reset -> s0 is granted first; s1 gets the next grant only after s0's GAP completes; a second simultaneous request goes to s1, not s0 (alternation).
- Hold-off: s1 asserts tvalid during the GAP of an s0 frame -> s1_tready=0 throughout; grant=10 on the first cycle after IDLE is re-entered.
- Drop: tlast accepted, tx_en never rises -> drop_err pulses once at cycle 4096 after tlast; after GAP, state returns to IDLE.
- Mid-frame stall: s0 deasserts tvalid for 100 cycles between bytes 1 and 2 -> grant stays 01, s1 is not granted, and the frame completes normally.
- Reset mid-SEND: rstn pulled low after byte 1 -> all outputs go to 0 immediately; after release, state is IDLE with s0 preferred.

Source files
------------

// File: rtl/nfca_pkg.sv
// Shared types and timing constants for the NFC-A TX path.
// GAP_CYCLES derives from the PCD frame delay time expressed in carrier periods.
package nfca_pkg;

   localparam int FDT_FC            = 1172;
   localparam int CLK_PER_FC        = 6;
   localparam int GAP_CYCLES_DEF    = FDT_FC * CLK_PER_FC;
   localparam int START_TIMEOUT_DEF = 4096;
   localparam int CNT_W_DEF         = 13;
   localparam int NUM_REQ           = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_START,
      ST_WAIT_END,
      ST_GAP
   } arb_state_e;

   typedef struct packed {
      logic [7:0] tdata;
      logic [3:0] tdatab;
      logic       tlast;
   } tx_beat_t;

   // One-hot winner; on a tie the requester that did not send last wins.
   function automatic logic [NUM_REQ-1:0] pick_grant(input logic [NUM_REQ-1:0] req,
                                                     input logic               last_owner);
      logic [NUM_REQ-1:0] g;
      case (req)
         2'b01:   g = 2'b01;
         2'b10:   g = 2'b10;
         2'b11:   g = last_owner ? 2'b01 : 2'b10;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/nfca_tx_arbiter.sv
// Frame-locked two-way arbiter in front of the NFC-A TX framer; holds off new
// grants until the previous frame has left the antenna plus the FDT gap.
module nfca_tx_arbiter
   import nfca_pkg::*;
#(
   parameter int GAP_CYCLES    = GAP_CYCLES_DEF,
   parameter int START_TIMEOUT = START_TIMEOUT_DEF,
   parameter int CNT_W         = CNT_W_DEF
) (
   input  logic       rstn,
   input  logic       clk,
   input  logic       s0_tvalid,
   output logic       s0_tready,
   input  logic [7:0] s0_tdata,
   input  logic [3:0] s0_tdatab,
   input  logic       s0_tlast,
   input  logic       s1_tvalid,
   output logic       s1_tready,
   input  logic [7:0] s1_tdata,
   input  logic [3:0] s1_tdatab,
   input  logic       s1_tlast,
   output logic       m_tvalid,
   input  logic       m_tready,
   output logic [7:0] m_tdata,
   output logic [3:0] m_tdatab,
   output logic       m_tlast,
   input  logic       tx_en,
   output logic [1:0] grant,
   output logic       busy,
   output logic       drop_err
);

   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   arb_state_e                   state_q, state_d;
   logic       [NUM_REQ-1:0]     grant_q, grant_d;
   logic                         last_q, last_d;
   logic                         drop_q, drop_d;
   logic       [CNT_W-1:0]       cnt_q, cnt_d;

   tx_beat_t   [NUM_REQ-1:0]     req_beat;
   logic       [NUM_REQ-1:0]     req_vld;
   logic       [NUM_REQ-1:0]     req_rdy;
   tx_beat_t                     mux_beat;
   logic                         hs_last;

   assign req_beat[0] = {s0_tdata, s0_tdatab, s0_tlast};
   assign req_beat[1] = {s1_tdata, s1_tdatab, s1_tlast};
   assign req_vld     = {s1_tvalid, s0_tvalid};

   genvar g;
   generate
      for (g = 0; g < NUM_REQ; g++) begin : g_rdy
         assign req_rdy[g] = grant_q[g] & m_tready;
      end
   endgenerate

   assign s0_tready = req_rdy[0];
   assign s1_tready = req_rdy[1];

   // AND-OR mux: grant is one-hot or zero, so the bus is all-zero with no owner.
   always_comb begin
      mux_beat = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         mux_beat = mux_beat | (req_beat[i] & {$bits(tx_beat_t){grant_q[i]}});
      end
   end

   assign m_tvalid = |(grant_q & req_vld);
   assign m_tdata  = mux_beat.tdata;
   assign m_tdatab = mux_beat.tdatab;
   assign m_tlast  = mux_beat.tlast;
   assign hs_last  = m_tvalid & m_tready & m_tlast;

   assign grant    = grant_q;
   assign busy     = (state_q != ST_IDLE);
   assign drop_err = drop_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      drop_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req_vld) begin
               grant_d = pick_grant(req_vld, last_q);
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (hs_last) begin
               last_d  = grant_q[1];
               grant_d = '0;
               state_d = ST_WAIT_START;
            end
         end
         ST_WAIT_START: begin
            // tx_en wins over the timeout if both land on the same cycle
            if (tx_en) begin
               state_d = ST_WAIT_END;
            end else if (cnt_q == TO_LAST) begin
               drop_d  = 1'b1;
               state_d = ST_GAP;
            end
         end
         ST_WAIT_END: begin
            if (!tx_en) state_d = ST_GAP;
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase

      // Counter restarts on every state change and saturates otherwise.
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= 1'b1;
         drop_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_nfca_tx_arbiter.sv
// Randomized bench for nfca_tx_arbiter: drivers push expected beats into per-requester
// queues, a negedge monitor runs a transaction-level model and checks every cycle.
module tb_nfca_tx_arbiter;

   localparam int GAP  = 1172 * 6;
   localparam int TOUT = 4096;
   localparam int INF  = 32'h7fffffff;

   typedef struct packed {
      logic [7:0] d;
      logic [3:0] b;
      logic       l;
   } beat_t;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       s0_tvalid = 1'b0, s1_tvalid = 1'b0;
   logic       s0_tready, s1_tready;
   logic [7:0] s0_tdata = '0, s1_tdata = '0;
   logic [3:0] s0_tdatab = '0, s1_tdatab = '0;
   logic       s0_tlast = 1'b0, s1_tlast = 1'b0;
   logic       m_tvalid, m_tready, m_tlast, tx_en;
   logic [7:0] m_tdata;
   logic [3:0] m_tdatab;
   logic [1:0] grant;
   logic       busy, drop_err;

   always #5 clk = ~clk;

   nfca_tx_arbiter dut (
      .rstn(rstn), .clk(clk),
      .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata),
      .s0_tdatab(s0_tdatab), .s0_tlast(s0_tlast),
      .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata),
      .s1_tdatab(s1_tdatab), .s1_tlast(s1_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
      .m_tdatab(m_tdatab), .m_tlast(m_tlast),
      .tx_en(tx_en), .grant(grant), .busy(busy), .drop_err(drop_err)
   );

   int    cyc = 0;
   int    checks = 0, errors = 0;
   beat_t q0[$], q1[$];
   int    tx_delay = 5, tx_len = 50;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- reference model + monitor ----------------
   int         owner = -1, last_own = 1, idle_edge = 0, h_edge = 0, post = 0;
   bit         rel_pend = 0;
   logic [1:0] tv_prev = '0;
   logic       tx_prev = 1'b0;

   always @(negedge clk) begin : mon
      bit         drop_exp;
      bit         exp_vld;
      logic [1:0] eg;
      beat_t      e, bus, drv;
      if (!rstn) begin
         owner = -1; last_own = 1; post = 0; rel_pend = 0;
         idle_edge = cyc + 1;
      end else begin
         drop_exp = 0;
         // post-frame tracking uses the tx_en level sampled on this cycle's edge
         if (post == 1 && cyc > h_edge) begin
            if (tx_prev) post = 2;
            else if (cyc == h_edge + TOUT) begin
               drop_exp = 1; post = 0; idle_edge = cyc + GAP;
            end
         end else if (post == 2 && !tx_prev) begin
            post = 0; idle_edge = cyc + GAP;
         end
         if (rel_pend) begin
            last_own = owner; owner = -1; h_edge = cyc; post = 1; idle_edge = INF; rel_pend = 0;
         end
         if (owner < 0 && post == 0 && cyc - 1 >= idle_edge && tv_prev != 2'b00) begin
            if (tv_prev == 2'b11) owner = (last_own == 1) ? 0 : 1;
            else                  owner = tv_prev[1] ? 1 : 0;
         end
         eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
         chk("grant", grant, eg);
         chk("busy", busy, !(owner < 0 && post == 0 && cyc >= idle_edge));
         chk("drop_err", drop_err, drop_exp);
         exp_vld = (owner == 0) ? s0_tvalid : (owner == 1) ? s1_tvalid : 1'b0;
         chk("m_tvalid", m_tvalid, exp_vld);
         chk("s0_tready", s0_tready, (owner == 0) && m_tready);
         chk("s1_tready", s1_tready, (owner == 1) && m_tready);
         drv = (owner == 0) ? {s0_tdata, s0_tdatab, s0_tlast} :
               (owner == 1) ? {s1_tdata, s1_tdatab, s1_tlast} : '0;
         bus = {m_tdata, m_tdatab, m_tlast};
         chk("m_bus", bus, drv);
         if (exp_vld && m_tready) begin
            if ((owner == 0 && q0.size() == 0) || (owner == 1 && q1.size() == 0)) begin
               checks++; errors++;
               $display("FAIL sb_underrun cyc=%0d got=beat from s%0d want=none", cyc, owner);
            end else begin
               e = (owner == 0) ? q0.pop_front() : q1.pop_front();
               chk($sformatf("sb_beat_s%0d", owner), bus, e);
               rel_pend = e.l;
            end
         end
      end
      tv_prev = {s1_tvalid, s0_tvalid};
      tx_prev = tx_en;
   end

   // ---------------- framer model: m_tready backpressure and tx_en ----------------
   initial begin
      m_tready = 1'b0;
      forever begin
         @(posedge clk); #1;
         m_tready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      tx_en = 1'b0;
      forever begin
         @(negedge clk);
         if (rstn && m_tvalid && m_tready && m_tlast) begin
            @(posedge clk); #1;
            if (tx_len > 0) begin
               if (tx_delay > 0) begin repeat (tx_delay) @(posedge clk); #1; end
               tx_en = 1'b1;
               repeat (tx_len) @(posedge clk); #1;
               tx_en = 1'b0;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (cyc > 95000) begin
         $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
         $fatal(1, "watchdog");
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic rdy(input int s);
      return (s == 0) ? s0_tready : s1_tready;
   endfunction

   task automatic drive(input int s, input logic v, input beat_t b);
      if (s == 0) begin s0_tvalid = v; {s0_tdata, s0_tdatab, s0_tlast} = b; end
      else        begin s1_tvalid = v; {s1_tdata, s1_tdatab, s1_tlast} = b; end
   endtask

   task automatic wait_hs(input int s);
      int t = 0;
      @(negedge clk);
      while (!rdy(s) && t < 30000) begin @(negedge clk); t++; end
      if (t >= 30000) begin
         checks++; errors++;
         $display("FAIL hs_timeout_s%0d cyc=%0d got=no tready want=tready", s, cyc);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      int t = 0;
      do begin @(negedge clk); t++; end while ((busy || tx_en) && t < 20000);
      if (t >= 20000) begin
         checks++; errors++;
         $display("FAIL idle_timeout cyc=%0d got=busy want=idle", cyc);
      end
      @(posedge clk); #1;
   endtask

   task automatic rand_bytes(output logic [7:0] d [4]);
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
   endtask

   task automatic send_frame(input int s, input int n, input logic [7:0] d [4],
                             input int stall_at, input int stall_len);
      beat_t bs [4];
      for (int k = 0; k < n; k++) begin
         bs[k].d = d[k];
         bs[k].l = (k == n - 1);
         bs[k].b = bs[k].l ? 4'($urandom_range(1, 8)) : 4'd8;
         if (s == 0) q0.push_back(bs[k]); else q1.push_back(bs[k]);
      end
      for (int k = 0; k < n; k++) begin
         drive(s, 1'b1, bs[k]);
         wait_hs(s);
         if (k + 1 == stall_at) begin
            drive(s, 1'b0, bs[k]);
            repeat (stall_len) @(posedge clk); #1;
         end
      end
      drive(s, 1'b0, '0);
   endtask

   initial begin
      logic [7:0] da [4];
      logic [7:0] db [4];
      beat_t      b1;

      // reset: requests present but nothing may pass
      repeat (2) @(posedge clk); #1;
      drive(0, 1'b1, {8'h93, 4'd8, 1'b0});
      drive(1, 1'b1, {8'h26, 4'd7, 1'b1});
      repeat (2) @(posedge clk); #1;
      chk("rst_grant", grant, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_drop", drop_err, 1'b0);
      chk("rst_m_tvalid", m_tvalid, 1'b0);
      chk("rst_m_bus", {m_tdata, m_tdatab, m_tlast}, '0);
      chk("rst_s0_tready", s0_tready, 1'b0);
      chk("rst_s1_tready", s1_tready, 1'b0);
      drive(0, 1'b0, '0);
      drive(1, 1'b0, '0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;

      // contention after reset, s0 stalls mid-frame while s1 waits
      tx_delay = $urandom_range(0, 40); tx_len = $urandom_range(20, 100);
      rand_bytes(da); rand_bytes(db);
      fork
         send_frame(0, 3, da, 1, 100);
         send_frame(1, $urandom_range(1, 4), db, 0, 0);
      join
      wait_idle();

      // single {93,20,xx} frame with long tx_en; s1 arrives during the gap
      tx_delay = 10; tx_len = 3000;
      rand_bytes(da); da[0] = 8'h93; da[1] = 8'h20;
      rand_bytes(db);
      fork
         send_frame(0, 3, da, 0, 0);
         begin
            repeat (4500) @(posedge clk); #1;
            send_frame(1, $urandom_range(1, 4), db, 0, 0);
         end
      join
      wait_idle();

      // dropped frame: tx_en never rises
      tx_len = 0;
      rand_bytes(da);
      send_frame(0, $urandom_range(1, 4), da, 0, 0);
      wait_idle();

      // tie after s0 sent last -> s1 first
      tx_delay = $urandom_range(0, 40); tx_len = $urandom_range(20, 100);
      rand_bytes(da); rand_bytes(db);
      fork
         send_frame(0, $urandom_range(1, 4), da, 0, 0);
         send_frame(1, $urandom_range(1, 4), db, 0, 0);
      join
      wait_idle();

      // reset mid-frame, then tie -> s0 preferred again
      b1 = {8'($urandom), 4'd8, 1'b0};
      q0.push_back(b1);
      drive(0, 1'b1, b1);
      wait_hs(0);
      rstn = 1'b0;
      #1;
      chk("mid_rst_grant", grant, 2'b00);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_m_tvalid", m_tvalid, 1'b0);
      chk("mid_rst_m_bus", {m_tdata, m_tdatab, m_tlast}, '0);
      chk("mid_rst_s0_tready", s0_tready, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, '0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      tx_delay = $urandom_range(0, 40); tx_len = $urandom_range(20, 100);
      rand_bytes(da); rand_bytes(db);
      fork
         send_frame(0, $urandom_range(1, 4), da, 0, 0);
         send_frame(1, $urandom_range(1, 4), db, 0, 0);
      join
      wait_idle();

      chk("sb_left_s0", q0.size(), 0);
      chk("sb_left_s1", q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
